pixel_stream_tx: RTL
====================

# pixel_stream_tx

Frame streamer that reads a stored image from a synchronous single-port memory and emits it as a strobed pixel stream (one pixel per o_strb, programmable idle gap between strobes) to feed the filter2d input port. It is the transmit end of the i_strb/i_data pixel interface. It replaces hand-driven stimulus in system builds and supports back-to-back multi-frame runs.

## Interface
Parameters:
- IMG_W, 256, pixels per line; power of two
- IMG_H, 256, lines per frame; power of two
- DW, 8, pixel width
- AW, log2(IMG_W*IMG_H) = 16, memory address width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  one-cycle request to begin a run; honored only in IDLE
- abort  in  1  stop the run immediately; no done pulse
- gap  in  5  idle cycles between strobes; sampled on accepted start
- n_frames  in  2  frames per run minus 1 (0 → 1 frame, 3 → 4 frames); sampled on accepted start
- mem_rd  out  1  memory read enable
- mem_addr  out  AW  read address; pixel index = row*IMG_W + col
- mem_data  in  DW  read data; valid the cycle after mem_rd
- o_strb  out  1  pixel valid, one cycle per pixel
- o_data  out  DW  pixel value; holds last value when o_strb=0
- o_sof  out  1  with o_strb, first pixel of a frame
- o_eol  out  1  with o_strb, last pixel of a line (col = IMG_W-1)
- o_eof  out  1  with o_strb, last pixel of a frame
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at normal run completion

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: all outputs 0 except o_data (held). start=1 → latch gap, n_frames; clear address and frame counters; → RUN.
- RUN: issue mem_rd every gap+1 cycles, first issue on the first RUN cycle. Address increments by 1 after each issue; wraps IMG_W*IMG_H-1 → 0 and increments frame counter. After the read of the last pixel of frame n_frames → DRAIN.
- DRAIN: no reads; wait for the two-stage read pipeline to empty; the cycle after the last o_strb → DONE.
- DONE: done=1 for one cycle → IDLE.
- Output pipeline: mem_rd, delayed two registers, becomes o_strb. mem_data is registered into o_data. sof/eol/eof are derived from the issued address and frame counter and delayed alongside.
- busy = 1 in RUN, DRAIN and DONE; 0 in IDLE.
- start while not IDLE: ignored. gap/n_frames changes mid-run: no effect.
- abort (any non-IDLE state): → IDLE at next edge. Pipeline valid bits cleared, so no o_strb follows. No done pulse. If abort and start occur together in IDLE, start wins.
- reset_n=0 at an edge, including mid-run: state IDLE, counters 0, all outputs 0 including o_data.

## Timing
- start accepted in cycle T: mem_rd=1, mem_addr=0 in cycle T+1.
- First o_strb in T+3 with o_data=mem[0] and o_sof=1.
- Strobe period is exactly gap+1 cycles, continuous across frame boundaries. gap=16 gives 17 cycles; gap=0 gives a strobe every cycle.
- Last o_strb in cycle L: done=1 and busy=1 in L+1; busy=0 in L+2.
- Run length = (n_frames+1)*IMG_W*IMG_H strobes.

## Structure
- Shared package filter2d_pkg: IMG_W, IMG_H, DW, AW defaults; state enum (IDLE, RUN, DRAIN, DONE).
- Sub-module pixel_addr_gen: gap down-counter, address counter with wrap, frame counter. Outputs issue, addr, last_of_line, last_of_frame, last_of_run.
- Top level holds the FSM and the two-stage output pipeline.

## Test plan
- Reset: hold reset_n=0 for 2 edges with start=1 → all outputs 0, no mem_rd; release → IDLE, busy=0.
- Memory preloaded with mem[a]=a[7:0]; gap=16, n_frames=0; start at T:
  - first o_strb at T+3 with o_data=0x00 and o_sof=1; strobes 17 cycles apart;
  - 65536 strobes in total; o_eol on every 256th strobe; o_eof and o_data=0xFF on the last strobe;
  - done exactly one cycle after the last strobe.
- gap=0, n_frames=2: 196608 consecutive-cycle strobes; address wraps twice; o_sof 3 times, o_eof 3 times; single done.
- Mid-run: start pulse and change gap to 3 → ignored; spacing stays 17; no second run.
- abort after the 100th strobe → no further o_strb or mem_rd; busy=0 next cycle; no done. A new start restarts at address 0 with o_sof.
- reset_n=0 for one edge mid-frame → outputs cleared next cycle; stream does not resume until a new start, which begins at address 0.

Source files
------------

// File: rtl/filter2d_pkg.sv
// Shared definitions for the filter2d pixel path: image geometry defaults
// and the streamer state encoding.
package filter2d_pkg;

  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Column index is the low bits of the linear address (IMG_W is a power of two).
  function automatic logic is_last_col(input logic [31:0] addr, input int col_w);
    logic [31:0] mask;
    mask = (32'd1 << col_w) - 32'd1;
    return ((addr & mask) == mask);
  endfunction

endpackage

// File: rtl/pixel_stream_tx_addr_gen.sv
// Read scheduler for the pixel streamer: paces reads every gap+1 cycles,
// walks the linear image address with wrap, and counts frames in a run.
module pixel_addr_gen
  import filter2d_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          run,
  input  logic [4:0]    gap,
  input  logic [1:0]    n_frames,
  output logic          issue,
  output logic [AW-1:0] addr,
  output logic          first_of_frame,
  output logic          last_of_line,
  output logic          last_of_frame,
  output logic          last_of_run
);

  localparam int            COL_W    = $clog2(IMG_W);
  localparam logic [AW-1:0] ADDR_MAX = AW'(IMG_W * IMG_H - 1);

  logic          issue_r;
  logic [AW-1:0] addr_r;
  logic [1:0]    frame_r;
  logic [4:0]    cnt_r;
  logic [4:0]    gap_r;
  logic [1:0]    nf_r;
  logic          last_of_run_s;

  assign issue          = issue_r;
  assign addr           = addr_r;
  assign first_of_frame = (addr_r == {AW{1'b0}});
  assign last_of_line   = is_last_col(32'(addr_r), COL_W);
  assign last_of_frame  = (addr_r == ADDR_MAX);
  assign last_of_run_s  = issue_r && (addr_r == ADDR_MAX) && (frame_r == nf_r);
  assign last_of_run    = last_of_run_s;

  // Pace reads and advance address/frame after every issued read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issue_r <= 1'b0;
      addr_r  <= {AW{1'b0}};
      frame_r <= 2'd0;
      cnt_r   <= 5'd0;
      gap_r   <= 5'd0;
      nf_r    <= 2'd0;
    end else if (load) begin
      // First read goes out on the very first RUN cycle.
      issue_r <= 1'b1;
      addr_r  <= {AW{1'b0}};
      frame_r <= 2'd0;
      cnt_r   <= 5'd0;
      gap_r   <= gap;
      nf_r    <= n_frames;
    end else if (!run) begin
      issue_r <= 1'b0;
      addr_r  <= {AW{1'b0}};
      frame_r <= 2'd0;
      cnt_r   <= 5'd0;
    end else if (issue_r) begin
      // cnt_r holds the idle cycles still owed before the next read.
      cnt_r   <= gap_r;
      issue_r <= (gap_r == 5'd0) && !last_of_run_s;
      if (addr_r == ADDR_MAX) begin
        addr_r  <= {AW{1'b0}};
        frame_r <= frame_r + 2'd1;
      end else begin
        addr_r  <= addr_r + AW'(1);
      end
    end else if (cnt_r == 5'd1) begin
      cnt_r   <= 5'd0;
      issue_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_r - 5'd1;
      issue_r <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame streamer: reads a stored image from a synchronous memory and emits
// it as a strobed pixel stream with start/end-of-line/frame markers.
module pixel_stream_tx
  import filter2d_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [4:0]    gap,
  input  logic [1:0]    n_frames,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          o_strb,
  output logic [DW-1:0] o_data,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic          busy,
  output logic          done
);

  state_t        state_r;
  logic          accept_s;
  logic          abort_s;
  logic          run_s;
  logic          issue_s;
  logic [AW-1:0] addr_s;
  logic          sof_s;
  logic          eol_s;
  logic          eof_s;
  logic          last_run_s;
  logic          v1_r;
  logic          sof1_r;
  logic          eol1_r;
  logic          eof1_r;

  assign accept_s = (state_r == IDLE) && start;
  assign abort_s  = (state_r != IDLE) && abort;
  assign run_s    = (state_r == RUN) && !abort;
  assign mem_rd   = issue_s;
  assign mem_addr = addr_s;

  pixel_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_addr_gen (
    .clk            (clk),
    .reset_n        (reset_n),
    .load           (accept_s),
    .run            (run_s),
    .gap            (gap),
    .n_frames       (n_frames),
    .issue          (issue_s),
    .addr           (addr_s),
    .first_of_frame (sof_s),
    .last_of_line   (eol_s),
    .last_of_frame  (eof_s),
    .last_of_run    (last_run_s)
  );

  // Run sequencing with registered busy/done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort_s) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= RUN;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          if (last_run_s) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          // Last strobe is on the output and nothing is behind it.
          if (o_strb && !v1_r) begin
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage output pipeline: read cycle -> data cycle -> registered pixel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_r   <= 1'b0;
      sof1_r <= 1'b0;
      eol1_r <= 1'b0;
      eof1_r <= 1'b0;
      o_strb <= 1'b0;
      o_sof  <= 1'b0;
      o_eol  <= 1'b0;
      o_eof  <= 1'b0;
      o_data <= {DW{1'b0}};
    end else if (abort_s) begin
      // Drop in-flight pixels; o_data keeps its last value.
      v1_r   <= 1'b0;
      sof1_r <= 1'b0;
      eol1_r <= 1'b0;
      eof1_r <= 1'b0;
      o_strb <= 1'b0;
      o_sof  <= 1'b0;
      o_eol  <= 1'b0;
      o_eof  <= 1'b0;
    end else begin
      v1_r   <= issue_s;
      sof1_r <= issue_s & sof_s;
      eol1_r <= issue_s & eol_s;
      eof1_r <= issue_s & eof_s;
      o_strb <= v1_r;
      o_sof  <= v1_r & sof1_r;
      o_eol  <= v1_r & eol1_r;
      o_eof  <= v1_r & eof1_r;
      if (v1_r) begin
        o_data <= mem_data;
      end else begin
        o_data <= o_data;
      end
    end
  end

endmodule
